// File: rtl/config_reg_arbiter.sv
// Round-robin arbiter sharing the single config_reg bank port among NUM_REQ requesters.
// Define CFG_INIT_SEQ_EN to add a boot sequence writing INIT_VALS to addr 0..6 after reset.
module config_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int RD_LAT = 1,
  parameter logic [7*DW-1:0] INIT_VALS = {{(6*DW){1'b0}}, {DW{1'b1}}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [AW*NUM_REQ-1:0] req_addr,
  input  logic [DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic                  cfg_write,
  output logic [AW-1:0]         cfg_address,
  output logic [DW-1:0]         cfg_data_in,
  input  logic [DW-1:0]         cfg_data_out
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] RO_ADDR = '1;

  typedef enum logic [2:0] {IDLE, WR, RD, RESP, INIT} state_t;
`ifdef CFG_INIT_SEQ_EN
  localparam state_t RST_ST = INIT;
  logic [2:0] init_cnt;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t state, state_nx;
  logic [PW-1:0] ptr, win, win_q;
  logic [PW:0]   idx;
  logic          found;
  logic [CW-1:0] rd_cnt;
  logic          drop;
  logic [AW-1:0] win_addr;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign win_addr = req_addr[win*AW +: AW];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RST_ST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = req_we[win] ? WR : RD;
      WR:   state_nx = RESP;
      RD:   if (rd_cnt == '0) state_nx = RESP;
      RESP: state_nx = IDLE;
`ifdef CFG_INIT_SEQ_EN
      INIT: if (init_cnt == 3'd7) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      cfg_write   <= 1'b0;
      cfg_address <= '0;
      cfg_data_in <= '0;
      ptr         <= '0;
      win_q       <= '0;
      rd_cnt      <= '0;
      drop        <= 1'b0;
`ifdef CFG_INIT_SEQ_EN
      init_cnt    <= '0;
`endif
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      cfg_write <= 1'b0;
      case (state)
        IDLE: if (found) begin
          gnt         <= NUM_REQ'(1) << win;
          win_q       <= win;
          cfg_address <= win_addr;
          cfg_data_in <= req_wdata[win*DW +: DW];
          // gpio_in is read-only: the write is swallowed and reported via err.
          drop        <= req_we[win] && (win_addr == RO_ADDR);
          cfg_write   <= req_we[win] && (win_addr != RO_ADDR);
          rd_cnt      <= CW'(RD_LAT - 1);
        end
        WR: begin
          ack <= gnt;
          err <= drop;
        end
        RD: begin
          if (rd_cnt == '0) begin
            rdata <= cfg_data_out;
            ack   <= gnt;
          end else begin
            rd_cnt <= rd_cnt - CW'(1);
          end
        end
        RESP: begin
          gnt <= '0;
          ptr <= (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
        end
`ifdef CFG_INIT_SEQ_EN
        INIT: if (init_cnt != 3'd7) begin
          cfg_write   <= 1'b1;
          cfg_address <= AW'(init_cnt);
          cfg_data_in <= INIT_VALS[init_cnt*DW +: DW];
          init_cnt    <= init_cnt + 3'd1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_config_reg_arbiter.sv
// Scoreboarded random bench for config_reg_arbiter: rounds of held requests, reference model
// derives service order, read data, err and ack latency from the arbitration rules.
module tb_config_reg_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0, req_we = '0;
  logic [AW*NUM_REQ-1:0] req_addr = '0;
  logic [DW*NUM_REQ-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    gnt, ack;
  logic                  err, busy, cfg_write;
  logic [DW-1:0]         rdata, cfg_data_in, cfg_data_out;
  logic [AW-1:0]         cfg_address;

  always #5 clk = ~clk;

  config_reg_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .cfg_write(cfg_write), .cfg_address(cfg_address), .cfg_data_in(cfg_data_in),
    .cfg_data_out(cfg_data_out));

  // Stand-in for the config_reg bank; address 7 is the gpio input.
  logic [DW-1:0] bank [8];
  logic [DW-1:0] gpio;
  always @(posedge clk) if (cfg_write) bank[cfg_address] <= cfg_data_in;
  assign cfg_data_out = (cfg_address == 3'd7) ? gpio : bank[cfg_address];

  typedef struct {
    int            id;
    logic          err;
    logic [DW-1:0] rdata;
    int            gap;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int errors = 0, checks = 0;
  int cyc = 0, last_evt = 0;
  int wr_seen = 0, exp_wr = 0;
  int m_ptr = 0;
  logic [DW-1:0] m_mem [8];
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_rdata = '0;
`ifdef CFG_INIT_SEQ_EN
    m_mem[0] = 16'hFFFF;
    for (int a = 1; a < 7; a++) m_mem[a] = '0;
`endif
  endtask

  // Monitor: pops one expectation per ack, plus always-on protocol checks.
  always @(negedge clk) begin
    if (reset) begin
      if ($countones(gnt) > 1) chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
      if (cfg_write) begin
        if (gnt == '0) begin
`ifndef CFG_INIT_SEQ_EN
          chk("write_without_gnt", 32'(gnt), 32'd1);
`endif
        end else begin
          wr_seen++;
          chk("write_ro_addr", 32'(cfg_address == 3'd7), 32'd0);
        end
      end
      if (|ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          me = sb.pop_front();
          chk("ack_id", 32'(ack), 32'(NUM_REQ'(1) << me.id));
          chk("gnt_at_ack", 32'(gnt), 32'(NUM_REQ'(1) << me.id));
          chk("err", 32'(err), 32'(me.err));
          chk("rdata", 32'(rdata), 32'(me.rdata));
          chk("latency", 32'(cyc - last_evt), 32'(me.gap));
          last_evt = cyc;
        end
      end else if (err) begin
        chk("err_without_ack", 32'(err), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int t = 0; t < 50 && busy; t++) @(negedge clk);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One round: raise all masked requests together, model their service order, wait for all acks.
  task automatic run_round(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] we,
                           input logic [AW*NUM_REQ-1:0] ad, input logic [DW*NUM_REQ-1:0] wd);
    int first;
    int last;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    gpio = DW'($urandom);
    first = 1;
    last = m_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      logic [AW-1:0] a;
      exp_t e;
      k = (m_ptr + i) % NUM_REQ;
      if (mask[k]) begin
        a = ad[k*AW +: AW];
        e.id = k;
        e.err = we[k] && (a == 3'd7);
        if (we[k]) begin
          if (a != 3'd7) begin
            m_mem[a] = wd[k*DW +: DW];
            exp_wr++;
          end
        end else begin
          m_rdata = (a == 3'd7) ? gpio : m_mem[a];
        end
        e.rdata = m_rdata;
        if (we[k]) e.gap = first ? 2 : 3;
        else       e.gap = first ? RD_LAT + 1 : RD_LAT + 2;
        first = 0;
        last = k;
        sb.push_back(e);
      end
    end
    m_ptr = (last + 1) % NUM_REQ;
    req_we = we;
    req_addr = ad;
    req_wdata = wd;
    req = mask;
    last_evt = cyc;
    for (int t = 0; t < 100 && req != '0; t++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    if (req != '0) begin
      chk("round_timeout", 32'(req), 32'd0);
      req = '0;
      sb.delete();
    end
  endtask

  task automatic rand_round();
    logic [NUM_REQ-1:0] mask, we;
    logic [AW*NUM_REQ-1:0] ad;
    logic [DW*NUM_REQ-1:0] wd;
    mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
    we = NUM_REQ'($urandom);
    for (int k = 0; k < NUM_REQ; k++) begin
      ad[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? 3'd7 : AW'($urandom);
      wd[k*DW +: DW] = DW'($urandom);
    end
    run_round(mask, we, ad, wd);
  endtask

  initial begin
    for (int a = 0; a < 8; a++) begin
      bank[a] = '0;
      m_mem[a] = '0;
    end
    gpio = 16'h5A3C;
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_cfg_write", 32'(cfg_write), 32'd0);
    chk("rst_cfg_address", 32'(cfg_address), 32'd0);
`ifdef CFG_INIT_SEQ_EN
    chk("rst_busy", 32'(busy), 32'd1);
`else
    chk("rst_busy", 32'(busy), 32'd0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_idle();

    // Write then read back through requester 0.
    run_round(2'b01, 2'b01, {3'd0, 3'd2}, {16'h0, 16'h1234});
    run_round(2'b01, 2'b00, {3'd0, 3'd2}, '0);
    // Both requesters writing, alternating grants.
    repeat (3) run_round(2'b11, 2'b11, {3'd4, 3'd3}, {16'hAAAA, 16'h5555});
    // Read-only gpio address: dropped write, then read of live gpio.
    run_round(2'b01, 2'b01, {3'd0, 3'd7}, {16'h0, 16'hBEEF});
    run_round(2'b01, 2'b00, {3'd0, 3'd7}, '0);
    // Leave pointer at 1 with nonzero rdata, then reset in the middle of a read by requester 1.
    run_round(2'b01, 2'b00, {3'd0, 3'd2}, '0);
    @(negedge clk);
    req_we = 2'b00;
    req_addr = {3'd2, 3'd0};
    req = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_cfg_write", 32'(cfg_write), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
`ifndef CFG_INIT_SEQ_EN
    chk("midrst_busy", 32'(busy), 32'd0);
`endif
    req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_idle();
    // Pointer was cleared, so requester 0 must win first.
    run_round(2'b11, 2'b00, {3'd2, 3'd2}, '0);

    repeat (150) rand_round();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    chk("write_count", 32'(wr_seen), 32'(exp_wr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
